power_accum: RTL and testbench

- Upstream stage of the Log2 converter in the receiver signal chain.
- Takes signed baseband/ADC samples with a valid strobe, squares each sample, and sums the squares over a fixed window of WINDOW accepted samples.
- At the end of each window it emits one averaged 32-bit power word with a one-cycle valid pulse. This word feeds the Log2 inputs x and valid_i directly.

---
 rtl/power_accum.sv | 197 +++++++++++++++++++
 tb/tb_power_accum.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/power_accum.sv
// power_accum -- windowed signal power estimator feeding the Log2 converter.
//
// Squares each accepted signed sample and sums the squares over WINDOW
// accepted samples. At the end of every window it emits the sum shifted
// right by SHIFT, clamped to OW bits, with a one-cycle valid strobe.
//
// Optional feature macro: POWER_ACCUM_DC_BLOCK_EN
//   When defined, each window's arithmetic mean of raw samples is tracked
//   in dc_mean. The value squared is (sample - dc_mean) instead of the raw
//   sample, so a constant offset contributes no power from the window after
//   the one that measured it.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   sample_i  [IW-1:0] signed input sample
//   valid_i   sample_i valid this cycle
//   clear_i   synchronous window abort/restart (drops partial window)
//   power_o   [OW-1:0] averaged window power, unsigned
//   valid_o   one-cycle strobe, power_o/sat_o updated
//   sat_o     power_o was clamped for this window (qualified by valid_o)
module power_accum #(
  parameter int IW     = 16,
  parameter int WINDOW = 256,
  parameter int SHIFT  = 8,
  parameter int OW     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] sample_i,
  input  logic          valid_i,
  input  logic          clear_i,
  output logic [OW-1:0] power_o,
  output logic          valid_o,
  output logic          sat_o
);

  localparam int LW = $clog2(WINDOW);
  localparam int CW = (LW > 0) ? LW : 1;
`ifdef POWER_ACCUM_DC_BLOCK_EN
  localparam int SQ_W = 2*IW + 2;
`else
  localparam int SQ_W = 2*IW;
`endif
  localparam int ACC_W = SQ_W + LW;
  // Extended width for the shift/clamp; always wider than OW so the clamp
  // compare has at least one bit above the output range.
  localparam int EW = (ACC_W > OW) ? ACC_W : OW + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WINDOW - 1);
  localparam logic [EW-1:0] OUT_MAX  = {{(EW-OW){1'b0}}, {OW{1'b1}}};

  // Stage 1
  logic              s1_valid_q, s1_valid_d;
  logic [SQ_W-1:0]   sq_q, sq_d;
  // Stage 2
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [OW-1:0]     power_q, power_d;
  logic              valid_q, valid_d;
  logic              sat_q, sat_d;

  logic              take;
  logic              close;
  logic [ACC_W-1:0]  sum;
  logic [EW-1:0]     sum_ext;
  logic [EW-1:0]     shifted;
  logic signed [SQ_W-1:0] sq_in;
  logic signed [SQ_W-1:0] prod;

  // A sample coincident with clear_i is dropped.
  assign take = valid_i && !clear_i;

  // Window closes when stage 1 carries the last sample; clear_i wins.
  assign close = s1_valid_q && (cnt_q == LAST_CNT) && !clear_i;

`ifdef POWER_ACCUM_DC_BLOCK_EN
  logic signed [IW-1:0] dc_mean_q, dc_mean_d;
  logic [IW-1:0]        s1_raw_q, s1_raw_d;
  logic [IW+LW-1:0]     raw_q, raw_d;
  logic [IW+LW-1:0]     raw_total;
  logic [IW-1:0]        new_mean;
  logic [IW-1:0]        mean_eff;
  logic signed [IW:0]   diff;

  assign raw_total = raw_q + {{LW{s1_raw_q[IW-1]}}, s1_raw_q};
  // Taking the upper IW bits equals an arithmetic right shift by LW
  // truncated back to IW bits; the mean always fits in IW bits.
  assign new_mean  = raw_total[IW+LW-1:LW];
  // Forward the freshly computed mean to a sample arriving on the closing
  // edge, so every sample of a window sees the previous window's mean.
  assign mean_eff  = close ? new_mean : dc_mean_q;

  always_comb begin
    diff  = {sample_i[IW-1], sample_i} - {mean_eff[IW-1], mean_eff};
    sq_in = {{(SQ_W-IW-1){diff[IW]}}, diff};
    prod  = sq_in * sq_in;
  end

  always_comb begin
    s1_raw_d  = take ? sample_i : s1_raw_q;
    raw_d     = raw_q;
    dc_mean_d = dc_mean_q;
    if (clear_i) begin
      raw_d = '0;
    end else if (s1_valid_q) begin
      raw_d = (cnt_q == '0) ? {{LW{s1_raw_q[IW-1]}}, s1_raw_q} : raw_total;
      if (close) begin
        dc_mean_d = new_mean;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dc_mean_q <= '0;
      s1_raw_q  <= '0;
      raw_q     <= '0;
    end else begin
      dc_mean_q <= dc_mean_d;
      s1_raw_q  <= s1_raw_d;
      raw_q     <= raw_d;
    end
  end
`else
  // Sign-extend to the square width; the low SQ_W bits of the product are
  // exact, including (-2^(IW-1))^2 = 2^(2*IW-2).
  always_comb begin
    sq_in = {{IW{sample_i[IW-1]}}, sample_i};
    prod  = sq_in * sq_in;
  end
`endif

  // Stage 1: square the accepted sample.
  always_comb begin
    s1_valid_d = take;
    sq_d       = take ? prod : sq_q;
  end

  assign sum     = acc_q + {{LW{1'b0}}, sq_q};
  assign sum_ext = EW'(sum);
  assign shifted = sum_ext >> SHIFT;

  // Stage 2: accumulate, close window, clamp.
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    power_d = power_q;
    sat_d   = sat_q;
    valid_d = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (s1_valid_q) begin
      // First sample of a window loads fresh; no separate clear needed
      // between back-to-back windows.
      acc_d = (cnt_q == '0) ? {{LW{1'b0}}, sq_q} : sum;
      if (cnt_q == LAST_CNT) begin
        cnt_d   = '0;
        valid_d = 1'b1;
        if (shifted > OUT_MAX) begin
          power_d = '1;
          sat_d   = 1'b1;
        end else begin
          power_d = shifted[OW-1:0];
          sat_d   = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      sq_q       <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      power_q    <= '0;
      valid_q    <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      sq_q       <= sq_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      power_q    <= power_d;
      valid_q    <= valid_d;
      sat_q      <= sat_d;
    end
  end

  assign power_o = power_q;
  assign valid_o = valid_q;
  assign sat_o   = sat_q;

endmodule

// File: tb/tb_power_accum.sv
// tb_power_accum -- directed self-checking bench for power_accum.
// Two instances share the stimulus: WINDOW=4 with SHIFT=2 and SHIFT=0.
module tb_power_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample_i = '0;
  logic        valid_i = 1'b0;
  logic        clear_i = 1'b0;

  logic [31:0] power_a, power_b;
  logic        valid_a, valid_b, sat_a, sat_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_send_cyc = 0;

  // Pulse monitors (a: SHIFT=2, b: SHIFT=0)
  int          pulses_a = 0, pulses_b = 0;
  int          last_cyc_a = 0, prev_cyc_a = 0;
  int          last_cyc_b = 0;
  logic [31:0] last_pow_a = '0, last_pow_b = '0;
  logic        last_sat_a = 1'b0, last_sat_b = 1'b0;

  power_accum #(.IW(16), .WINDOW(4), .SHIFT(2), .OW(32)) u_dut_a (
    .clk(clk), .rst(rst), .sample_i(sample_i), .valid_i(valid_i),
    .clear_i(clear_i), .power_o(power_a), .valid_o(valid_a), .sat_o(sat_a)
  );

  power_accum #(.IW(16), .WINDOW(4), .SHIFT(0), .OW(32)) u_dut_b (
    .clk(clk), .rst(rst), .sample_i(sample_i), .valid_i(valid_i),
    .clear_i(clear_i), .power_o(power_b), .valid_o(valid_b), .sat_o(sat_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_a) begin
      pulses_a   = pulses_a + 1;
      prev_cyc_a = last_cyc_a;
      last_cyc_a = cyc;
      last_pow_a = power_a;
      last_sat_a = sat_a;
    end
    if (valid_b) begin
      pulses_b   = pulses_b + 1;
      last_cyc_b = cyc;
      last_pow_b = power_b;
      last_sat_b = sat_b;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, got, got, exp, exp);
    end else begin
      $display("check %s: %0d ok", tag, got);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the sample's
  // capturing posedge.
  task automatic send(input logic [15:0] s, input int gap);
    last_send_cyc = cyc;
    sample_i = s;
    valid_i  = 1'b1;
    @(negedge clk);
    valid_i  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int base_a, base_b;

  initial begin
    repeat (2) @(negedge clk);
    check_val("reset_power_a", power_a, 32'd0);
    check_val("reset_valid_a", {31'd0, valid_a}, 32'd0);
    check_val("reset_sat_b", {31'd0, sat_b}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

`ifndef POWER_ACCUM_DC_BLOCK_EN
    // 1: four +100 back to back
    base_a = pulses_a; base_b = pulses_b;
    for (int i = 0; i < 4; i++) send(16'd100, 0);
    repeat (5) @(negedge clk);
    check_val("t1_pulses_a", pulses_a - base_a, 32'd1);
    check_val("t1_latency", last_cyc_a - last_send_cyc, 32'd2);
    check_val("t1_power_a", last_pow_a, 32'd10000);
    check_val("t1_sat_a", {31'd0, last_sat_a}, 32'd0);
    check_val("t1_power_b", last_pow_b, 32'd40000);

    // 2: extremes with 3-cycle gaps
    do_reset();
    base_a = pulses_a; base_b = pulses_b;
    send(16'h8000, 3);
    send(16'h7FFF, 3);
    send(16'h0000, 3);
    send(16'hFFFF, 0);
    repeat (5) @(negedge clk);
    check_val("t2_pulses_a", pulses_a - base_a, 32'd1);
    check_val("t2_pulses_b", pulses_b - base_b, 32'd1);
    check_val("t2_latency", last_cyc_b - last_send_cyc, 32'd2);
    check_val("t2_power_a", last_pow_a, 32'd536854528);
    check_val("t2_power_b", last_pow_b, 32'd2147418114);

    // 3: saturation on SHIFT=0, then a zero window
    do_reset();
    base_a = pulses_a; base_b = pulses_b;
    for (int i = 0; i < 4; i++) send(16'h8000, 0);
    repeat (6) @(negedge clk);
    check_val("t3_power_b", last_pow_b, 32'hFFFF_FFFF);
    check_val("t3_sat_b", {31'd0, last_sat_b}, 32'd1);
    check_val("t3_power_a", last_pow_a, 32'd1073741824);
    check_val("t3_sat_a", {31'd0, last_sat_a}, 32'd0);
    check_val("t3_hold_power_b", power_b, 32'hFFFF_FFFF);
    check_val("t3_hold_sat_b", {31'd0, sat_b}, 32'd1);
    for (int i = 0; i < 4; i++) send(16'd0, 0);
    repeat (5) @(negedge clk);
    check_val("t3_zero_power_b", last_pow_b, 32'd0);
    check_val("t3_zero_sat_b", {31'd0, last_sat_b}, 32'd0);
    check_val("t3_pulses_b", pulses_b - base_b, 32'd2);

    // 4: eight consecutive +2
    do_reset();
    base_a = pulses_a; base_b = pulses_b;
    for (int i = 0; i < 8; i++) send(16'd2, 0);
    repeat (5) @(negedge clk);
    check_val("t4_pulses_a", pulses_a - base_a, 32'd2);
    check_val("t4_spacing", last_cyc_a - prev_cyc_a, 32'd4);
    check_val("t4_power_a", last_pow_a, 32'd4);
    check_val("t4_power_b", last_pow_b, 32'd16);

    // 5: clear beats a window close, clear drops in-flight and coincident
    do_reset();
    base_a = pulses_a; base_b = pulses_b;
    for (int i = 0; i < 4; i++) send(16'd7, 0);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    repeat (4) @(negedge clk);
    check_val("t5_clear_close_pulses", pulses_a - base_a, 32'd0);
    for (int i = 0; i < 3; i++) send(16'd1000, 0);
    clear_i  = 1'b1;
    sample_i = 16'd5000;
    valid_i  = 1'b1;
    @(negedge clk);
    clear_i  = 1'b0;
    valid_i  = 1'b0;
    for (int i = 0; i < 4; i++) send(16'd10, 0);
    repeat (5) @(negedge clk);
    check_val("t5_pulses_a", pulses_a - base_a, 32'd1);
    check_val("t5_power_a", last_pow_a, 32'd100);
    check_val("t5_power_b", last_pow_b, 32'd400);

    // 6: reset mid-window; outputs must read 0 during reset
    base_a = pulses_a; base_b = pulses_b;
    for (int i = 0; i < 3; i++) send(16'd1000, 0);
    rst = 1'b1;
    #1;
    check_val("t6_rst_power_a", power_a, 32'd0);
    check_val("t6_rst_power_b", power_b, 32'd0);
    check_val("t6_rst_valid", {30'd0, valid_a, valid_b}, 32'd0);
    check_val("t6_rst_sat", {30'd0, sat_a, sat_b}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send(16'd10, 0);
    repeat (5) @(negedge clk);
    check_val("t6_pulses_a", pulses_a - base_a, 32'd1);
    check_val("t6_power_a", last_pow_a, 32'd100);
`else
    // DC block: 4x +500 then 4x +500 back to back; mean removed in window 2
    base_a = pulses_a; base_b = pulses_b;
    for (int i = 0; i < 4; i++) send(16'd500, 0);
    repeat (2) @(negedge clk);
    check_val("dc_w1_power_a", last_pow_a, 32'd250000);
    check_val("dc_w1_power_b", last_pow_b, 32'd1000000);
    for (int i = 0; i < 4; i++) send(16'd500, 0);
    repeat (5) @(negedge clk);
    check_val("dc_pulses_a", pulses_a - base_a, 32'd2);
    check_val("dc_w2_power_a", last_pow_a, 32'd0);
    check_val("dc_w2_power_b", last_pow_b, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
